hub75_rx: RTL and testbench

Receive-side model and checker for the LED matrix drive interface, the panel end of the link driven by the row/column sequencer. It watches `sclk`, `lat`, `blank`, the row address and the RGB data lines, all in the system clock domain. Its own shift register and output latch mirror those in the panel. Latched rows are exposed through a column read port, and protocol faults are flagged as sticky errors. It is instantiated in the top-level loopback bench and, optionally, on the FPGA next to the real panel connector for self-test.

---
 rtl/hub75_pkg.sv | 14 +
 rtl/hub75_rx_sync_edge.sv | 26 ++
 rtl/hub75_rx.sv | 195 +++++++++++++++++++
 tb/tb_hub75_rx.sv | 257 +++++++++++++++++++++++++
 4 files changed

// File: rtl/hub75_pkg.sv
// Shared constants and types for the HUB75 receive-side model.
package hub75_pkg;

  localparam int COLS_PER_PANEL = 32;
  localparam int ROW_AW         = 3;

  typedef logic [5:0] rgb_pair_t;

  typedef enum logic {
    S_SYNC = 1'b0,
    S_RUN  = 1'b1
  } rx_state_t;

endpackage

// File: rtl/hub75_rx_sync_edge.sv
// Two-flop input register with rise detection on the registered pair.
module sync_edge (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic d_i,
  output logic q_o,
  output logic rise_o
);

  logic q_q;
  logic qq_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      q_q  <= 1'b0;
      qq_q <= 1'b0;
    end else begin
      q_q  <= d_i;
      qq_q <= q_q;
    end
  end

  assign q_o    = q_q;
  assign rise_o = q_q & ~qq_q;

endmodule

// File: rtl/hub75_rx.sv
// Panel-end model of the HUB75 link: shift register, output latch, row readback and frame counting.
// Define HUB75_RX_CHECK_EN to build the protocol checker (sync FSM, shift counter, sticky error flags).
module hub75_rx
  import hub75_pkg::*;
#(
  parameter  int NUM_PANELS = 1,
  parameter  int FRAME_CW   = 16,
  localparam int NCOLS      = COLS_PER_PANEL * NUM_PANELS,
  localparam int COL_AW     = $clog2(NCOLS)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                sclk,
  input  logic                lat,
  input  logic                blank,
  input  logic [ROW_AW-1:0]   disp_row,
  input  logic [2:0]          rgb1,
  input  logic [2:0]          rgb2,
  input  logic [COL_AW-1:0]   rd_col,
  output logic [5:0]          rd_rgb,
  output logic                row_valid,
  output logic [ROW_AW-1:0]   row_addr,
  output logic                frame_done,
  output logic [FRAME_CW-1:0] frame_cnt,
  output logic                err_count,
  output logic                err_lat_unblanked,
  output logic                err_row_seq
);

  logic sclk_rise;
  logic lat_rise;
  logic blank_q;
  logic unused_sclk_q;
  logic unused_lat_q;
  logic unused_blank_rise;

  sync_edge u_sclk_sync (
    .clk_i  (clk),
    .rst_ni (rst),
    .d_i    (sclk),
    .q_o    (unused_sclk_q),
    .rise_o (sclk_rise)
  );

  sync_edge u_lat_sync (
    .clk_i  (clk),
    .rst_ni (rst),
    .d_i    (lat),
    .q_o    (unused_lat_q),
    .rise_o (lat_rise)
  );

  sync_edge u_blank_sync (
    .clk_i  (clk),
    .rst_ni (rst),
    .d_i    (blank),
    .q_o    (blank_q),
    .rise_o (unused_blank_rise)
  );

  logic [2:0]              rgb1_q;
  logic [2:0]              rgb2_q;
  logic [ROW_AW-1:0]       disp_row_q;
  rgb_pair_t [NCOLS-1:0]   sreg_q, sreg_d;
  rgb_pair_t [NCOLS-1:0]   lreg_q, lreg_d;
  logic [ROW_AW-1:0]       row_addr_q, row_addr_d;
  logic                    row_valid_q, row_valid_d;
  logic                    frame_done_q, frame_done_d;
  logic [FRAME_CW-1:0]     frame_cnt_q, frame_cnt_d;

  // The latch takes the post-shift image so a coincident sclk/lat edge pair captures the final word.
  always_comb begin
    sreg_d       = sreg_q;
    lreg_d       = lreg_q;
    row_addr_d   = row_addr_q;
    row_valid_d  = 1'b0;
    frame_done_d = 1'b0;
    frame_cnt_d  = frame_cnt_q;
    if (sclk_rise) begin
      sreg_d = {sreg_q[NCOLS-2:0], rgb1_q, rgb2_q};
    end
    if (lat_rise) begin
      lreg_d      = sreg_d;
      row_addr_d  = disp_row_q;
      row_valid_d = 1'b1;
      if (disp_row_q == ROW_AW'(7)) begin
        frame_done_d = 1'b1;
        frame_cnt_d  = frame_cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rgb1_q       <= '0;
      rgb2_q       <= '0;
      disp_row_q   <= '0;
      sreg_q       <= '0;
      lreg_q       <= '0;
      row_addr_q   <= '0;
      row_valid_q  <= 1'b0;
      frame_done_q <= 1'b0;
      frame_cnt_q  <= '0;
    end else begin
      rgb1_q       <= rgb1;
      rgb2_q       <= rgb2;
      disp_row_q   <= disp_row;
      sreg_q       <= sreg_d;
      lreg_q       <= lreg_d;
      row_addr_q   <= row_addr_d;
      row_valid_q  <= row_valid_d;
      frame_done_q <= frame_done_d;
      frame_cnt_q  <= frame_cnt_d;
    end
  end

  always_comb begin
    rd_rgb = '0;
    if (int'(rd_col) < NCOLS) begin
      rd_rgb = lreg_q[rd_col];
    end
  end

  assign row_valid  = row_valid_q;
  assign row_addr   = row_addr_q;
  assign frame_done = frame_done_q;
  assign frame_cnt  = frame_cnt_q;

`ifdef HUB75_RX_CHECK_EN
  localparam int              CNT_W    = $clog2(NCOLS + 2);
  localparam logic [CNT_W-1:0] CNT_SAT  = CNT_W'(NCOLS + 1);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(NCOLS);

  rx_state_t        state_q, state_d;
  logic [CNT_W-1:0] shift_cnt_q, shift_cnt_d;
  logic             err_count_q, err_count_d;
  logic             err_unblk_q, err_unblk_d;
  logic             err_seq_q, err_seq_d;

  // The count checked at a latch already includes any shift landing in the same clk.
  always_comb begin
    state_d     = state_q;
    shift_cnt_d = shift_cnt_q;
    err_count_d = err_count_q;
    err_unblk_d = err_unblk_q;
    err_seq_d   = err_seq_q;
    if (sclk_rise && (shift_cnt_q != CNT_SAT)) begin
      shift_cnt_d = shift_cnt_q + 1'b1;
    end
    if (lat_rise) begin
      if (state_q == S_RUN) begin
        if (shift_cnt_d != CNT_FULL) begin
          err_count_d = 1'b1;
        end
        if (!blank_q) begin
          err_unblk_d = 1'b1;
        end
        if (disp_row_q != ROW_AW'(row_addr_q + 1'b1)) begin
          err_seq_d = 1'b1;
        end
      end
      state_d     = S_RUN;
      shift_cnt_d = sclk_rise ? CNT_W'(1) : '0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= S_SYNC;
      shift_cnt_q <= '0;
      err_count_q <= 1'b0;
      err_unblk_q <= 1'b0;
      err_seq_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      shift_cnt_q <= shift_cnt_d;
      err_count_q <= err_count_d;
      err_unblk_q <= err_unblk_d;
      err_seq_q   <= err_seq_d;
    end
  end

  assign err_count         = err_count_q;
  assign err_lat_unblanked = err_unblk_q;
  assign err_row_seq       = err_seq_q;
`else
  logic unused_blank_q;

  assign unused_blank_q    = blank_q;
  assign err_count         = 1'b0;
  assign err_lat_unblanked = 1'b0;
  assign err_row_seq       = 1'b0;
`endif

endmodule

// File: tb/tb_hub75_rx.sv
// Directed bench for hub75_rx: shifting, latching, readback, frame counting, checker flags and reset.
module tb_hub75_rx;

`ifdef HUB75_RX_CHECK_EN
  localparam bit CK = 1'b1;
`else
  localparam bit CK = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        sclk = 1'b0;
  logic        lat = 1'b0;
  logic        blank = 1'b1;
  logic [2:0]  disp_row = '0;
  logic [2:0]  rgb1 = '0;
  logic [2:0]  rgb2 = '0;
  logic [4:0]  rd_col = '0;
  logic [6:0]  rd_col2 = '0;

  logic [5:0]  rd_rgb, rd_rgb2;
  logic        row_valid, row_valid2;
  logic [2:0]  row_addr, row_addr2;
  logic        frame_done, frame_done2;
  logic [15:0] frame_cnt;
  logic [1:0]  frame_cnt2;
  logic        err_count, err_lat_unblanked, err_row_seq;
  logic        err_count2, err_lat_unblanked2, err_row_seq2;

  int n_checks = 0;
  int n_fail   = 0;
  int rv_cnt   = 0;
  int fd_cnt   = 0;
  int exp_rv   = 0;

  always #5 clk = ~clk;

  hub75_rx dut (
    .clk               (clk),
    .rst               (rst),
    .sclk              (sclk),
    .lat               (lat),
    .blank             (blank),
    .disp_row          (disp_row),
    .rgb1              (rgb1),
    .rgb2              (rgb2),
    .rd_col            (rd_col),
    .rd_rgb            (rd_rgb),
    .row_valid         (row_valid),
    .row_addr          (row_addr),
    .frame_done        (frame_done),
    .frame_cnt         (frame_cnt),
    .err_count         (err_count),
    .err_lat_unblanked (err_lat_unblanked),
    .err_row_seq       (err_row_seq)
  );

  hub75_rx #(.NUM_PANELS(3), .FRAME_CW(2)) dut2 (
    .clk               (clk),
    .rst               (rst),
    .sclk              (sclk),
    .lat               (lat),
    .blank             (blank),
    .disp_row          (disp_row),
    .rgb1              (rgb1),
    .rgb2              (rgb2),
    .rd_col            (rd_col2),
    .rd_rgb            (rd_rgb2),
    .row_valid         (row_valid2),
    .row_addr          (row_addr2),
    .frame_done        (frame_done2),
    .frame_cnt         (frame_cnt2),
    .err_count         (err_count2),
    .err_lat_unblanked (err_lat_unblanked2),
    .err_row_seq       (err_row_seq2)
  );

  always @(negedge clk) begin
    if (row_valid)  rv_cnt++;
    if (frame_done) fd_cnt++;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic shift_word(input logic [5:0] w);
    rgb1 = w[5:3];
    rgb2 = w[2:0];
    sclk = 1'b1;
    tick(2);
    sclk = 1'b0;
    tick(2);
  endtask

  task automatic latch_row(input logic [2:0] r, input logic b);
    disp_row = r;
    blank    = b;
    lat      = 1'b1;
    tick(2);
    lat      = 1'b0;
    tick(2);
    blank    = 1'b1;
    exp_rv++;
  endtask

  task automatic shift_and_latch(input logic [5:0] w, input logic [2:0] r);
    rgb1     = w[5:3];
    rgb2     = w[2:0];
    disp_row = r;
    blank    = 1'b1;
    sclk     = 1'b1;
    lat      = 1'b1;
    tick(2);
    sclk     = 1'b0;
    lat      = 1'b0;
    tick(2);
    exp_rv++;
  endtask

  task automatic check_col(input string tag, input int col, input logic [5:0] exp);
    rd_col = 5'(col);
    #1;
    check(tag, rd_rgb, exp);
  endtask

  task automatic check_col2(input string tag, input int col, input logic [5:0] exp);
    rd_col2 = 7'(col);
    #1;
    check(tag, rd_rgb2, exp);
  endtask

  task automatic check_errs(input string tag, input logic ec, input logic eu, input logic es);
    check({tag, "_cnt"},   err_count,         ec);
    check({tag, "_unblk"}, err_lat_unblanked, eu);
    check({tag, "_seq"},   err_row_seq,       es);
  endtask

  initial begin
    tick(3);
    rst = 1'b1;
    tick(2);
    check("rst_row_valid", row_valid, 0);
    check("rst_row_addr", row_addr, 0);
    check("rst_frame_cnt", frame_cnt, 0);
    check("rst_frame_done", frame_done, 0);
    check_errs("rst", 1'b0, 1'b0, 1'b0);
    check_col("rst_col0", 0, 6'd0);

    // Row 0: words 0..31, first latch after reset moves the checker to run.
    for (int k = 0; k < 32; k++) shift_word(6'(k));
    latch_row(3'd0, 1'b1);
    check("r0_rv_pulses", rv_cnt, exp_rv);
    check("r0_row_addr", row_addr, 0);
    check_col("r0_col31", 31, 6'd0);
    check_col("r0_col0", 0, 6'd31);
    check_col("r0_col15", 15, 6'd16);
    check_errs("r0", 1'b0, 1'b0, 1'b0);

    // Row 1: 31 shifts then a shift coinciding with the latch.
    for (int k = 32; k < 63; k++) shift_word(6'(k));
    shift_and_latch(6'd63, 3'd1);
    check("r1_row_addr", row_addr, 1);
    check_col("r1_col0", 0, 6'd63);
    check_col("r1_col1", 1, 6'd62);
    check_col("r1_col31", 31, 6'd32);
    check_errs("r1", 1'b0, 1'b0, 1'b0);

    // Row 2: 31 shifts, counter restarted at 1 by the coincident edge.
    for (int k = 0; k < 31; k++) shift_word(6'h2A);
    latch_row(3'd2, 1'b1);
    check_errs("r2", 1'b0, 1'b0, 1'b0);

    // Row 3: 31 shifts is a short row.
    for (int k = 0; k < 31; k++) shift_word(6'h2A);
    latch_row(3'd3, 1'b1);
    check_errs("r3", CK, 1'b0, 1'b0);

    // Row 4: correct row, count error stays sticky.
    for (int k = 0; k < 32; k++) shift_word(6'h2A);
    latch_row(3'd4, 1'b1);
    check_errs("r4", CK, 1'b0, 1'b0);
    check_col("r4_col0", 0, 6'h2A);
    check_col2("r4_w_col95", 95, 6'd62);
    check_col2("r4_w_col94", 94, 6'd63);
    check_col2("r4_w_col96", 96, 6'd0);
    check_col2("r4_w_col127", 127, 6'd0);

    latch_row(3'd6, 1'b1);
    check_errs("r6_skip", CK, 1'b0, CK);

    latch_row(3'd7, 1'b0);
    check_errs("r7_unblk", CK, CK, CK);
    check("r7_row_addr", row_addr, 7);
    check("r7_frame_cnt", frame_cnt, 1);
    check("r7_fd_pulses", fd_cnt, 1);

    for (int f = 0; f < 3; f++)
      for (int r = 0; r < 8; r++) latch_row(3'(r), 1'b1);
    check("f3_frame_cnt", frame_cnt, 4);
    check("f3_fd_pulses", fd_cnt, 4);
    check("f3_frame_cnt_w2", frame_cnt2, 0);

    for (int r = 0; r < 8; r++) latch_row(3'(r), 1'b1);
    check("f4_frame_cnt", frame_cnt, 5);
    check("f4_fd_pulses", fd_cnt, 5);
    check("f4_frame_cnt_w2", frame_cnt2, 1);
    check("f4_rv_pulses", rv_cnt, exp_rv);

    // Reset in the middle of a row.
    rd_col = 5'd0;
    for (int k = 0; k < 5; k++) shift_word(6'd9);
    #3;
    rst = 1'b0;
    #1;
    check("mid_rst_row_valid", row_valid, 0);
    check("mid_rst_row_addr", row_addr, 0);
    check("mid_rst_frame_cnt", frame_cnt, 0);
    check("mid_rst_frame_cnt_w2", frame_cnt2, 0);
    check("mid_rst_frame_done", frame_done, 0);
    check("mid_rst_rd_rgb", rd_rgb, 0);
    check_errs("mid_rst", 1'b0, 1'b0, 1'b0);
    tick(2);
    rst = 1'b1;
    tick(2);

    // First row after re-sync is unchecked: short, unblanked, out of sequence.
    for (int k = 1; k < 32; k++) shift_word(6'(k));
    latch_row(3'd5, 1'b0);
    check_errs("sync", 1'b0, 1'b0, 1'b0);
    check("sync_row_addr", row_addr, 5);
    check_col("sync_col0", 0, 6'd31);
    check_col("sync_col30", 30, 6'd1);
    check_col("sync_col31", 31, 6'd0);

    for (int k = 0; k < 32; k++) shift_word(6'h15);
    latch_row(3'd6, 1'b1);
    check_errs("run2", 1'b0, 1'b0, 1'b0);
    check_col("run2_col31", 31, 6'h15);
    check("end_rv_pulses", rv_cnt, exp_rv);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
